// File: rtl/fsr_pkg.sv
// Shared types and helpers for frame_stream_reader: the controller state
// enum, default-width pixel views, channel expansion and the colour-bar
// table used by the optional test pattern (FSR_TEST_PATTERN_EN).
package fsr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fsr_state_e;

  // Default channel widths; the reader itself is parametrised and slices
  // words directly, these views are for code that works at default width.
  localparam int FSR_CH_IN  = 4;
  localparam int FSR_CH_OUT = 10;

  typedef struct packed {
    logic [FSR_CH_IN-1:0] r;
    logic [FSR_CH_IN-1:0] g;
    logic [FSR_CH_IN-1:0] b;
  } pixel_in_t;

  typedef struct packed {
    logic [FSR_CH_OUT-1:0] r;
    logic [FSR_CH_OUT-1:0] g;
    logic [FSR_CH_OUT-1:0] b;
  } pixel_out_t;

  // Colour index per bar, left to right: white first, black last.
  // Bit 2 = red, bit 1 = green, bit 0 = blue.
  localparam logic [2:0] BAR_COLOUR [8] = '{3'd7, 3'd6, 3'd5, 3'd4,
                                            3'd3, 3'd2, 3'd1, 3'd0};

  // Repeat the in_w-bit channel MSB-first and keep the top out_w bits,
  // so full scale maps to full scale (4'hF -> 10'h3FF, 4'h8 -> 10'h222).
  function automatic logic [31:0] expand_channel(input logic [31:0] v,
                                                 input int in_w,
                                                 input int out_w);
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < out_w; i++) begin
      res[out_w-1-i] = v[in_w-1-(i % in_w)];
    end
    return res;
  endfunction

endpackage

// File: rtl/fsr_skid_fifo.sv
// Small synchronous FIFO holding {eop, sop, pixel} words between the
// frame-buffer read return and the Avalon-ST output. A push while full is
// accepted only together with a pop (count unchanged).
module fsr_skid_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointer and occupancy update for this cycle's push/pop.
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
  end

  // Register pointers/count; storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/frame_stream_reader.sv
// Raster reader: walks a WIDTH x HEIGHT frame buffer, tracks reads in flight
// across the RAM's RD_LAT latency, expands RGB channels and emits one
// Avalon-ST packet (sop..eop) per frame. Reads are issued only when the skid
// FIFO is guaranteed room, so backpressure never loses a pixel.
// Optional: FSR_TEST_PATTERN_EN adds pattern_sel (8 vertical colour bars).
module frame_stream_reader
  import fsr_pkg::*;
#(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int CH_IN      = 4,
  parameter int CH_OUT     = 10,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = $clog2(WIDTH * HEIGHT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [3*CH_IN-1:0]  rd_data,
  output logic [3*CH_OUT-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sop,
  output logic                out_eop,
  output logic                frame_done,
  output logic                busy
`ifdef FSR_TEST_PATTERN_EN
  ,
  input  logic                pattern_sel
`endif
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FW    = 3 * CH_OUT + 2;
  // Tag bits carried with each read: [0]=sop [1]=eop, optionally
  // [4:2]=bar colour and [5]=pattern select.
`ifdef FSR_TEST_PATTERN_EN
  localparam int TAG_W = 6;
  localparam int BAR_W = (WIDTH >= 8) ? WIDTH / 8 : 1;
`else
  localparam int TAG_W = 2;
`endif

  fsr_state_e         state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [RD_LAT:0]    dl_vld_q, dl_vld_d;
  logic [TAG_W-1:0]   dl_tag_q [RD_LAT+1];
  logic [TAG_W-1:0]   dl_tag_d [RD_LAT+1];

  logic               issue, credit_ok, first_px, last_px, push;
  logic [TAG_W-1:0]   tag_issue, tag_ret;
  logic [3*CH_OUT-1:0] push_pixel;
  logic               fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [FW-1:0]      fifo_rd;
`ifdef FSR_TEST_PATTERN_EN
  int                 bar_idx;
`endif

  // Stage 0 of the delay line sits alongside rd_addr; stage RD_LAT lines up
  // with the returning rd_data and drives the FIFO push.
  assign push    = dl_vld_q[RD_LAT];
  assign tag_ret = dl_tag_q[RD_LAT];

  // Controller: credit check, raster counters, state and in-flight tracking.
  always_comb begin
    fifo_pop  = !fifo_empty && out_ready;
    // A slot freed by this cycle's pop can be reused by this cycle's issue.
    credit_ok = (int'(fifo_count) + int'(inflight_q) - (fifo_pop ? 1 : 0)) < FIFO_DEPTH;
    issue     = credit_ok && ((state_q == RUN) || ((state_q == IDLE) && enable));
    first_px  = (col_q == '0) && (row_q == '0);
    last_px   = (col_q == COL_W'(WIDTH - 1)) && (row_q == ROW_W'(HEIGHT - 1));

    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    rd_addr_d  = rd_addr_q;
    tag_issue  = '0;
    tag_issue[0] = first_px;
    tag_issue[1] = last_px;
`ifdef FSR_TEST_PATTERN_EN
    bar_idx = int'(col_q) / BAR_W;
    if (bar_idx > 7) bar_idx = 7;
    tag_issue[4:2] = BAR_COLOUR[bar_idx];
    tag_issue[5]   = pattern_sel;
`endif

    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (issue && last_px && !enable) state_d = DRAIN;
      DRAIN:   if ((inflight_q == '0) && fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      rd_addr_d = ADDR_W'(row_q) * ADDR_W'(WIDTH) + ADDR_W'(col_q);
      if (col_q == COL_W'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(HEIGHT - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    dl_vld_d    = {dl_vld_q[RD_LAT-1:0], issue};
    dl_tag_d[0] = issue ? tag_issue : '0;
    for (int k = 1; k <= RD_LAT; k++) dl_tag_d[k] = dl_tag_q[k-1];

    inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(push);
    busy_d     = (state_d != IDLE);
  end

  // Pixel written into the FIFO: expanded buffer data or a colour bar.
  always_comb begin
    push_pixel = {
      CH_OUT'(expand_channel(32'(rd_data[3*CH_IN-1 -: CH_IN]), CH_IN, CH_OUT)),
      CH_OUT'(expand_channel(32'(rd_data[2*CH_IN-1 -: CH_IN]), CH_IN, CH_OUT)),
      CH_OUT'(expand_channel(32'(rd_data[CH_IN-1 -: CH_IN]),   CH_IN, CH_OUT))
    };
`ifdef FSR_TEST_PATTERN_EN
    if (tag_ret[5]) begin
      push_pixel = {{CH_OUT{tag_ret[4]}}, {CH_OUT{tag_ret[3]}}, {CH_OUT{tag_ret[2]}}};
    end
`endif
  end

  // FSM, counters, read address and delay line registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      rd_addr_q  <= '0;
      busy_q     <= 1'b0;
      inflight_q <= '0;
      dl_vld_q   <= '0;
      for (int k = 0; k <= RD_LAT; k++) dl_tag_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      rd_addr_q  <= rd_addr_d;
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      dl_vld_q   <= dl_vld_d;
      for (int k = 0; k <= RD_LAT; k++) dl_tag_q[k] <= dl_tag_d[k];
    end
  end

  // The credit rule must make a push into a full FIFO without a pop impossible.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && fifo_full && !fifo_pop));
  end

  fsr_skid_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data ({tag_ret[1], tag_ret[0], push_pixel}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rd_addr    = rd_addr_q;
  assign busy       = busy_q;
  assign out_valid  = !fifo_empty;
  assign out_eop    = fifo_rd[FW-1];
  assign out_sop    = fifo_rd[FW-2];
  assign out_data   = fifo_rd[3*CH_OUT-1:0];
  assign frame_done = fifo_pop && out_eop;

endmodule

// File: tb/tb_frame_stream_reader.sv
// Bench for frame_stream_reader with a small frame and RD_LAT=2. A latency
// model of the frame buffer feeds rd_data; a negedge monitor logs accepted
// beats, and each test compares them against pixels computed from the
// buffer contents and the raster/expansion rules.
module tb_frame_stream_reader;

`ifdef FSR_TEST_PATTERN_EN
  localparam int W = 16;
`else
  localparam int W = 4;
`endif
  localparam int H      = 3;
  localparam int NPIX   = W * H;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 4;
  localparam int AW     = $clog2(NPIX);

  logic          clk = 1'b0;
  logic          reset, enable, out_ready;
  logic [AW-1:0] rd_addr;
  logic [11:0]   rd_data;
  logic [29:0]   out_data;
  logic          out_valid, out_sop, out_eop, frame_done, busy;
`ifdef FSR_TEST_PATTERN_EN
  logic          pattern_sel = 1'b0;
`endif

  frame_stream_reader #(
    .WIDTH(W), .HEIGHT(H), .CH_IN(4), .CH_OUT(10),
    .RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop),
    .frame_done(frame_done), .busy(busy)
`ifdef FSR_TEST_PATTERN_EN
    , .pattern_sel(pattern_sel)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- frame buffer model ----------------
  logic [11:0] mem [NPIX];
  logic [11:0] lat0, lat1;
  always @(posedge clk) begin
    lat0 <= mem[rd_addr];
    lat1 <= lat0;
  end
  assign rd_data = lat1;

  // ---------------- reference model ----------------
  bit pat_mode = 1'b0;

  function automatic logic [9:0] exp_ch(input logic [3:0] c);
    logic [11:0] rep;
    rep = {c, c, c};
    return rep[11:2];
  endfunction

  function automatic logic [29:0] exp_pixel(input int p);
    int bar;
    logic [2:0] c;
    if (pat_mode) begin
      bar = (p % W) / (W / 8);
      c = 3'(7 - bar);
      return {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
    end
    return {exp_ch(mem[p][11:8]), exp_ch(mem[p][7:4]), exp_ch(mem[p][3:0])};
  endfunction

  // ---------------- monitor ----------------
  logic [29:0] obs_data[$];
  logic        obs_sop[$];
  logic        obs_eop[$];
  int          obs_cyc[$];
  int          fd_cnt, first_valid_cyc, stall_err, max_cnt;
  logic        prev_stall;
  logic [31:0] prev_beat;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!out_valid || {out_eop, out_sop, out_data} !== prev_beat))
        stall_err++;
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_eop, out_sop, out_data};
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        obs_data.push_back(out_data);
        obs_sop.push_back(out_sop);
        obs_eop.push_back(out_eop);
        obs_cyc.push_back(cyc);
      end
      if (frame_done) fd_cnt++;
      if (int'(dut.fifo_count) > max_cnt) max_cnt = int'(dut.fifo_count);
    end
  end

  // ---------------- driver tasks ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic clear_logs();
    obs_data.delete(); obs_sop.delete(); obs_eop.delete(); obs_cyc.delete();
    fd_cnt = 0; first_valid_cyc = -1; stall_err = 0; max_cnt = 0;
  endtask

  task automatic fill_unique();
    for (int i = 0; i < NPIX; i++) mem[i] = 12'(i * 37 + 5);
  endtask

  task automatic wait_idle(input int max_cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (!busy && !out_valid) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic wait_beats(input int n, input int max_cyc, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (obs_data.size() >= n) begin timed_out = 1'b0; break; end
    end
  endtask

  // Pulse enable for one cycle; returns the cycle count at entry to RUN.
  task automatic pulse_enable(output int t0);
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 t0 = cyc; enable = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++; if (rd_addr !== '0) $display("FAIL reset_rd_addr got %0d want 0", rd_addr); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_sop !== 1'b0) $display("FAIL reset_out_sop got %b want 0", out_sop); else n_pass++;
    n_checks++; if (out_eop !== 1'b0) $display("FAIL reset_out_eop got %b want 0", out_eop); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single_frame();
    bit to;
    int t0, n;
    fill_unique(); pat_mode = 1'b0; clear_logs(); out_ready = 1'b1;
    pulse_enable(t0);
    wait_idle(500, to);
    n = obs_data.size();
    n_checks++; if (to !== 1'b0) $display("FAIL single_timeout got %b want 0", to); else n_pass++;
    n_checks++; if (n !== NPIX) $display("FAIL single_beat_count got %0d want %0d", n, NPIX); else n_pass++;
    for (int i = 0; i < n && i < NPIX; i++) begin
      n_checks++;
      if ({obs_sop[i], obs_eop[i], obs_data[i]} !== {1'(i == 0), 1'(i == NPIX - 1), exp_pixel(i)})
        $display("FAIL single_beat%0d got sop=%b eop=%b data=%h want sop=%b eop=%b data=%h",
                 i, obs_sop[i], obs_eop[i], obs_data[i], i == 0, i == NPIX - 1, exp_pixel(i));
      else n_pass++;
    end
    n_checks++; if (first_valid_cyc - t0 !== RD_LAT + 1)
      $display("FAIL first_valid_latency got %0d want %0d", first_valid_cyc - t0, RD_LAT + 1); else n_pass++;
    n_checks++; if (fd_cnt !== 1) $display("FAIL single_frame_done got %0d want 1", fd_cnt); else n_pass++;
    if (n >= 2) begin
      n_checks++; if (obs_cyc[n-1] - obs_cyc[0] !== NPIX - 1)
        $display("FAIL single_no_bubbles got span %0d want %0d", obs_cyc[n-1] - obs_cyc[0], NPIX - 1);
      else n_pass++;
    end
  endtask

  task automatic test_expansion();
    bit to;
    int t0;
    fill_unique(); mem[0] = 12'hF80; mem[1] = 12'h08F;
    pat_mode = 1'b0; clear_logs(); out_ready = 1'b1;
    pulse_enable(t0);
    wait_idle(500, to);
    n_checks++; if (obs_data.size() < 2 || obs_data[0] !== {10'h3FF, 10'h222, 10'h000})
      $display("FAIL expand_F80 got %h want %h", obs_data.size() > 0 ? obs_data[0] : 'x, {10'h3FF, 10'h222, 10'h000});
    else n_pass++;
    n_checks++; if (obs_data.size() < 2 || obs_data[1] !== {10'h000, 10'h222, 10'h3FF})
      $display("FAIL expand_08F got %h want %h", obs_data.size() > 1 ? obs_data[1] : 'x, {10'h000, 10'h222, 10'h3FF});
    else n_pass++;
  endtask

  task automatic test_random_ready();
    bit done;
    int n, errs;
    for (int i = 0; i < NPIX; i++) mem[i] = 12'($urandom_range(0, 4095));
    pat_mode = 1'b0; clear_logs(); done = 1'b0;
    @(posedge clk); #1 enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      if (fd_cnt >= 2) enable = 1'b0;
      if (!enable && !busy) begin done = 1'b1; break; end
    end
    out_ready = 1'b1; enable = 1'b0;
    n = obs_data.size(); errs = 0;
    for (int i = 0; i < n && i < 3 * NPIX; i++)
      if ({obs_sop[i], obs_eop[i], obs_data[i]} !==
          {1'(i % NPIX == 0), 1'(i % NPIX == NPIX - 1), exp_pixel(i % NPIX)}) errs++;
    n_checks++; if (done !== 1'b1) $display("FAIL random_timeout got %b want 1", done); else n_pass++;
    n_checks++; if (n !== 3 * NPIX) $display("FAIL random_beat_count got %0d want %0d", n, 3 * NPIX); else n_pass++;
    n_checks++; if (errs !== 0) $display("FAIL random_beat_data got %0d bad beats want 0", errs); else n_pass++;
    n_checks++; if (fd_cnt !== 3) $display("FAIL random_frame_done got %0d want 3", fd_cnt); else n_pass++;
    n_checks++; if (stall_err !== 0) $display("FAIL random_stall_stable got %0d changes want 0", stall_err); else n_pass++;
    n_checks++; if (max_cnt > DEPTH) $display("FAIL random_fifo_level got %0d want <= %0d", max_cnt, DEPTH); else n_pass++;
  endtask

  task automatic test_enable_drop();
    bit to;
    int n, errs;
    for (int i = 0; i < NPIX; i++) mem[i] = 12'($urandom_range(0, 4095));
    pat_mode = 1'b0; clear_logs(); out_ready = 1'b1;
    @(posedge clk); #1 enable = 1'b1;
    wait_beats(5, 200, to);
    enable = 1'b0;
    n_checks++; if (to !== 1'b0) $display("FAIL drop_start_timeout got %b want 0", to); else n_pass++;
    wait_idle(500, to);
    repeat (20) @(posedge clk);
    #1 n = obs_data.size(); errs = 0;
    for (int i = 0; i < n && i < NPIX; i++)
      if ({obs_sop[i], obs_eop[i], obs_data[i]} !== {1'(i == 0), 1'(i == NPIX - 1), exp_pixel(i)}) errs++;
    n_checks++; if (n !== NPIX) $display("FAIL drop_beat_count got %0d want %0d", n, NPIX); else n_pass++;
    n_checks++; if (errs !== 0) $display("FAIL drop_beat_data got %0d bad beats want 0", errs); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL drop_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (fd_cnt !== 1) $display("FAIL drop_frame_done got %0d want 1", fd_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit to;
    fill_unique(); pat_mode = 1'b0; clear_logs(); out_ready = 1'b1;
    @(posedge clk); #1 enable = 1'b1;
    wait_beats(7, 200, to);
    out_ready = 1'b0;
    n_checks++; if (to !== 1'b0) $display("FAIL rstmid_start_timeout got %b want 0", to); else n_pass++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else n_pass++;
    @(posedge clk); #1 reset = 1'b0;
    clear_logs(); out_ready = 1'b1; enable = 1'b1;
    wait_beats(1, 100, to);
    enable = 1'b0;
    n_checks++; if (to !== 1'b0 || obs_sop[0] !== 1'b1)
      $display("FAIL rstmid_first_sop got %b want 1", obs_data.size() > 0 ? obs_sop[0] : 1'bx);
    else n_pass++;
    n_checks++; if (to !== 1'b0 || obs_data[0] !== exp_pixel(0))
      $display("FAIL rstmid_first_addr0 got %h want %h", obs_data.size() > 0 ? obs_data[0] : 'x, exp_pixel(0));
    else n_pass++;
    wait_idle(500, to);
    n_checks++; if (obs_data.size() !== NPIX)
      $display("FAIL rstmid_refill_count got %0d want %0d", obs_data.size(), NPIX); else n_pass++;
  endtask

`ifdef FSR_TEST_PATTERN_EN
  task automatic test_pattern();
    bit to;
    int t0, errs;
    logic [29:0] white, black, yellow;
    white = {3{10'h3FF}}; black = '0; yellow = {10'h3FF, 10'h3FF, 10'h000};
    fill_unique(); pat_mode = 1'b1; pattern_sel = 1'b1; clear_logs(); out_ready = 1'b1;
    pulse_enable(t0);
    wait_idle(500, to);
    pattern_sel = 1'b0;
    errs = 0;
    for (int i = 0; i < obs_data.size() && i < NPIX; i++) if (obs_data[i] !== exp_pixel(i)) errs++;
    n_checks++; if (obs_data.size() !== NPIX) $display("FAIL pat_count got %0d want %0d", obs_data.size(), NPIX); else n_pass++;
    n_checks++; if (errs !== 0) $display("FAIL pat_bars got %0d bad pixels want 0", errs); else n_pass++;
    if (obs_data.size() >= 16) begin
      n_checks++; if (obs_data[0] !== white || obs_data[1] !== white)
        $display("FAIL pat_white got %h %h want %h", obs_data[0], obs_data[1], white); else n_pass++;
      n_checks++; if (obs_data[2] !== yellow || obs_data[3] !== yellow)
        $display("FAIL pat_bar1 got %h %h want %h", obs_data[2], obs_data[3], yellow); else n_pass++;
      n_checks++; if (obs_data[14] !== black || obs_data[15] !== black)
        $display("FAIL pat_black got %h %h want %h", obs_data[14], obs_data[15], black); else n_pass++;
    end
    pat_mode = 1'b0;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    prev_stall = 1'b0;
    clear_logs();
    test_reset();
    test_single_frame();
    test_expansion();
    test_random_ready();
    test_enable_drop();
    test_reset_mid();
`ifdef FSR_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_stream_reader.md
Name: frame_stream_reader

Overview:
- Parametrised raster reader that scans a WIDTH x HEIGHT frame buffer, issues read addresses and compensates for the RAM's fixed read latency.
- Expands packed RGB (CH_IN bits per channel) to CH_OUT bits per channel.
- Emits each frame as one Avalon-ST video packet (sop/eop, valid/ready) to the scaler/VGA sink or to edge_conv.
- Replaces free-running address counters that ignore read latency and backpressure.

Parameters:
- WIDTH, 320, pixels per line
- HEIGHT, 240, lines per frame
- CH_IN, 4, bits per colour channel in buffer word (word = 3*CH_IN, R in MSBs)
- CH_OUT, 10, bits per output colour channel (CH_OUT >= CH_IN)
- RD_LAT, 1, frame-buffer read latency in clocks (1..3)
- FIFO_DEPTH, 4, output skid FIFO entries (must be >= RD_LAT+1)
- ADDR_W, $clog2(WIDTH*HEIGHT), read address width (derived)

Ports:
- clk  in  1  single clock, same domain as buffer read port
- reset  in  1  synchronous, active-high
- enable  in  1  level; frames stream while high
- rd_addr  out  ADDR_W  frame-buffer read address
- rd_data  in  3*CH_IN  buffer data, valid RD_LAT clocks after rd_addr
- out_data  out  3*CH_OUT  {R,G,B}
- out_valid  out  1  Avalon-ST valid
- out_ready  in  1  Avalon-ST ready
- out_sop  out  1  first pixel of frame, qualified by out_valid
- out_eop  out  1  last pixel of frame, qualified by out_valid
- frame_done  out  1  one-cycle pulse when the eop beat is accepted
- busy  out  1  high in RUN or DRAIN

Behaviour:
- Reset values: rd_addr=0, out_valid=0, out_sop=0, out_eop=0, frame_done=0, busy=0. FIFO flushed, in-flight count cleared, row=col=0, state=IDLE. Reset mid-frame discards all pending pixels; no eop is produced for the aborted frame.
- States:
  - IDLE: enable=1 -> RUN at row=col=0.
  - RUN: issues reads. After issuing pixel (WIDTH-1, HEIGHT-1): if enable=1, wrap to (0,0) and stay in RUN; else go to DRAIN.
  - DRAIN: no new reads; when in-flight=0 and FIFO empty -> IDLE.
- Read issue: one address per cycle, only when fifo_count + inflight < FIFO_DEPTH. rd_addr = row*WIDTH + col, registered. col wraps at WIDTH-1 and increments row; row wraps at HEIGHT-1.
- A delay line of depth RD_LAT carries an issue flag plus sop/eop tags alongside each read. The returning rd_data is pushed into the FIFO with those tags. The credit rule guarantees no overflow; overflow is an assertion failure.
- Output: out_valid = FIFO not empty. A beat transfers when out_valid && out_ready. Data and tags must stay stable while valid && !ready.
- Latency: first out_valid occurs RD_LAT+1 clocks after entering RUN. With out_ready held high, the steady state is 1 pixel/clock with no bubbles.
- Expansion: each channel is repeated MSB-first and truncated to CH_OUT bits, so 4'hF -> 10'h3FF, 4'h8 -> 10'h222, 4'h0 -> 0.
- enable deasserted mid-frame: the current frame completes in full, including eop; no truncated packets. enable reasserted in DRAIN is ignored until IDLE.
- Simultaneous push and pop with a full FIFO is legal; the count is unchanged.
- frame_done is asserted in the cycle the eop beat transfers.

Optional Feature:
- Macro FSR_TEST_PATTERN_EN.
- Defined:
  - Adds input port pattern_sel (1 bit). When pattern_sel=1, pixel data pushed to the FIFO is replaced by 8 vertical colour bars, each WIDTH/8 wide.
  - Bar k uses colour index c = 7-k, with R = c[2], G = c[1], B = c[0]; each channel is all-ones or zero.
  - Timing, addresses and tags are unchanged. pattern_sel is sampled per pixel at issue time.
- Undefined: port absent and no pattern logic.

Decomposition:
- Package fsr_pkg holds:
  - the state enum (IDLE, RUN, DRAIN)
  - the pixel_in/pixel_out packed struct typedefs
  - the expand_channel function
  - the colour-bar constant table
- Sub-module fsr_skid_fifo: synchronous FIFO, parametrised width/depth, with push/pop/count/full/empty. It stores {eop, sop, data}.

Test Plan:
- WIDTH=4, HEIGHT=3, RD_LAT=2, out_ready=1, enable pulsed: exactly 12 beats. sop on beat 0, eop on beat 11, addresses 0..11 in order. frame_done pulses once. First valid arrives 3 clocks after RUN.
- Random out_ready (50%) over 3 frames: every beat's data equals expand(buffer[addr]) in order, with no drops or duplicates. FIFO never exceeds FIFO_DEPTH, and outputs stay stable while stalled.
- enable dropped at pixel 5 of frame 1: frame 1 completes through eop, then the block returns to IDLE (busy=0) and no further beats appear.
- reset at pixel 7 with out_ready=0: next cycle out_valid=0 and busy=0. After re-enable, the next beat is sop with addr 0.
- Expansion check: buffer word 12'hF80 -> out_data = {10'h3FF, 10'h222, 10'h000}.
- FSR_TEST_PATTERN_EN, WIDTH=16, pattern_sel=1: pixels 0-1 are white (all 10'h3FF), pixels 14-15 are black, and pixels 2-3 are {3FF, 3FF, 000}.
